// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel pipeline: default geometry, index widths
// and the names of the nine 3x3 window taps.
package sobel_pkg;

    localparam int unsigned DW       = 8;
    localparam int unsigned WIDTH    = 640;
    localparam int unsigned HEIGHT   = 480;
    localparam int unsigned COL_W    = $clog2(WIDTH);
    localparam int unsigned ROW_W    = $clog2(HEIGHT);

    // Row-major tap positions: top, middle, bottom rows; left, centre, right columns
    localparam int unsigned IN_TL    = 0;
    localparam int unsigned IN_TC    = 1;
    localparam int unsigned IN_TR    = 2;
    localparam int unsigned IN_ML    = 3;
    localparam int unsigned IN_MC    = 4;
    localparam int unsigned IN_MR    = 5;
    localparam int unsigned IN_BL    = 6;
    localparam int unsigned IN_BC    = 7;
    localparam int unsigned IN_BR    = 8;
    localparam int unsigned NUM_TAPS = 9;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage: asynchronous read, write-enabled
// synchronous write at the same address. Contents are never cleared.
module sobel_line_buffer #(
    parameter int unsigned DW    = sobel_pkg::DW,
    parameter int unsigned DEPTH = sobel_pkg::WIDTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata_c
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Sobel front end: synchronizes the byte strobe, keeps two line buffers and
// a 3x3 register window, and tracks row/column plus window/frame validity.
module sobel_window_gen #(
    parameter int unsigned DW     = sobel_pkg::DW,
    parameter int unsigned WIDTH  = sobel_pkg::WIDTH,
    parameter int unsigned HEIGHT = sobel_pkg::HEIGHT
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [DW-1:0]             DATA,
    input  logic                      DATAIN,
    output logic [DW-1:0]             IN0,
    output logic [DW-1:0]             IN1,
    output logic [DW-1:0]             IN2,
    output logic [DW-1:0]             IN3,
    output logic [DW-1:0]             IN4,
    output logic [DW-1:0]             IN5,
    output logic [DW-1:0]             IN6,
    output logic [DW-1:0]             IN7,
    output logic [DW-1:0]             IN8,
    output logic                      WIN_VALID,
    output logic [$clog2(WIDTH)-1:0]  COL,
    output logic [$clog2(HEIGHT)-1:0] ROW,
    output logic                      FRAME_DONE
);

    import sobel_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(HEIGHT);

    logic          s1;
    logic          s2;
    logic          acc_c;
    logic [DW-1:0] top_c;
    logic [DW-1:0] mid_c;
    logic          col_last_c;
    logic          row_last_c;
    logic          win_ok_c;
    logic [DW-1:0] win [NUM_TAPS];

    // Reset to 1 so a strobe already high when reset releases is not a byte
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= DATAIN;
            s2 <= s1;
        end
    end

    assign acc_c = s1 & ~s2;

    // lb0 holds the previous line, lb1 the line before it
    sobel_line_buffer #(
        .DW    (DW),
        .DEPTH (WIDTH),
        .AW    (CW)
    ) lb0 (
        .clk     (CLK),
        .we      (acc_c),
        .addr    (COL),
        .wdata   (DATA),
        .rdata_c (mid_c)
    );

    sobel_line_buffer #(
        .DW    (DW),
        .DEPTH (WIDTH),
        .AW    (CW)
    ) lb1 (
        .clk     (CLK),
        .we      (acc_c),
        .addr    (COL),
        .wdata   (mid_c),
        .rdata_c (top_c)
    );

    assign col_last_c = (COL == CW'(WIDTH - 1));
    assign row_last_c = (ROW == RW'(HEIGHT - 1));
    assign win_ok_c   = (ROW >= RW'(2)) && (COL >= CW'(2));

    // Position of the next expected byte; frames run back to back
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            COL <= '0;
            ROW <= '0;
        end else if (acc_c) begin
            if (col_last_c) begin
                COL <= '0;
                ROW <= row_last_c ? '0 : ROW + RW'(1);
            end else begin
                COL <= COL + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WIN_VALID  <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            WIN_VALID  <= acc_c & win_ok_c;
            FRAME_DONE <= acc_c & col_last_c & row_last_c;
        end
    end

    // Shift window left one column and load the new right column
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                win[i] <= '0;
            end
        end else if (acc_c) begin
            win[IN_TL] <= win[IN_TC];
            win[IN_TC] <= win[IN_TR];
            win[IN_TR] <= top_c;
            win[IN_ML] <= win[IN_MC];
            win[IN_MC] <= win[IN_MR];
            win[IN_MR] <= mid_c;
            win[IN_BL] <= win[IN_BC];
            win[IN_BC] <= win[IN_BR];
            win[IN_BR] <= DATA;
        end
    end

    assign IN0 = win[IN_TL];
    assign IN1 = win[IN_TC];
    assign IN2 = win[IN_TR];
    assign IN3 = win[IN_ML];
    assign IN4 = win[IN_MC];
    assign IN5 = win[IN_MR];
    assign IN6 = win[IN_BL];
    assign IN7 = win[IN_BC];
    assign IN8 = win[IN_BR];

endmodule
